pc_sequencer: RTL

//  Program-counter sequencer for the NeonFox core. Consumes the decoded control strobes
//  (pc_jmp/pc_brx/pc_brxt/pc_call/pc_ret) and supplies the fetch address.

---
 rtl/neonfox_pkg.sv | 32 +++
 rtl/pc_sequencer_return_stack.sv | 60 ++++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/neonfox_pkg.sv
// Shared types for the NeonFox program-counter sequencer: FSM states, branch
// condition codes, the fetch-address type and small helper functions.
package neonfox_pkg;

    typedef logic [15:0] pc_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_t;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_N      = 2'b01;
    localparam logic [1:0] COND_Z      = 2'b10;
    localparam logic [1:0] COND_P      = 2'b11;

    // flags arrive packed as {N,Z,P}
    function automatic logic cond_flag(input logic [1:0] sel, input logic [2:0] flags);
        case (sel)
            COND_N:  return flags[2];
            COND_Z:  return flags[1];
            COND_P:  return flags[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic pc_t sext10(input logic [9:0] v);
        return {{6{v[9]}}, v};
    endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return stack (LIFO) for call/ret. Build option PC_SEQ_STACK_GUARD_EN
// suppresses push-at-full and pop-at-empty; otherwise the pointer wraps silently.
import neonfox_pkg::*;

module return_stack #(
    parameter int STACK_DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  pc_t  push_data,
    output pc_t  top,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(STACK_DEPTH);

    pc_t            mem [STACK_DEPTH];
    logic [AW-1:0]  sp;
    logic [AW-1:0]  sp_dec;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign sp_dec = sp - AW'(1);
    assign top    = mem[sp_dec];
    assign full   = (count == (AW+1)'(STACK_DEPTH));
    assign empty  = (count == '0);

`ifdef PC_SEQ_STACK_GUARD_EN
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
`else
    assign do_push = push;
    assign do_pop  = pop;
`endif

    // count only tracks occupancy for full/empty; sp alone addresses the storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                sp <= sp + AW'(1);
                if (!full) count <= count + (AW+1)'(1);
            end else if (do_pop) begin
                sp <= sp_dec;
                if (!empty) count <= count - (AW+1)'(1);
            end
        end
    end

    // NOTE: storage has no reset; validity is tracked by sp/count, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[sp] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// NeonFox program-counter sequencer: fetch address, branch resolution, return stack
// and squash control. Build option PC_SEQ_STACK_GUARD_EN enables stack over/underflow guarding.
import neonfox_pkg::*;

module pc_sequencer #(
    parameter pc_t RESET_PC    = 16'h0000,
    parameter int  PIPE_DEPTH  = 2,
    parameter int  STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard,
    input  logic        p_cache_miss,
    input  logic        pc_jmp,
    input  logic        pc_brx,
    input  logic        pc_brxt,
    input  logic        pc_call,
    input  logic        pc_ret,
    input  logic [1:0]  cond_sel,
    input  logic [9:0]  I_field,
    input  logic [2:0]  flags,
    input  logic [15:0] jmp_target,
    output logic [15:0] pc,
    output logic        jmp_rst,
    output logic        brx_rst,
    output logic        squash,
    output logic        stack_err
);
    seq_state_t state;
    logic [2:0] flush_cnt;
    pc_t        chain [PIPE_DEPTH];
    pc_t        cur_pc;
    pc_t        stk_top;
    pc_t        ret_pc;
    logic       stk_full;
    logic       stk_empty;
    logic       advance;
    logic       evaluate;
    logic       br_taken;
    logic       jump;
    logic       push;
    logic       pop;
    logic       redirect;

    assign advance  = ~hazard & ~p_cache_miss;
    // strobes seen outside RUN belong to squashed fetches and are ignored
    assign evaluate = advance & (state == RUN);
    assign cur_pc   = chain[PIPE_DEPTH-1];
    assign br_taken = pc_brx & ((cond_sel == COND_ALWAYS) | (cond_flag(cond_sel, flags) ^ pc_brxt));
    assign jump     = pc_jmp | pc_call;
    assign pop      = evaluate & pc_ret;
    assign push     = evaluate & ~pc_ret & pc_call;
    assign redirect = evaluate & (pc_ret | jump | br_taken);

    return_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (cur_pc + 16'd1),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

`ifdef PC_SEQ_STACK_GUARD_EN
    assign ret_pc = stk_empty ? RESET_PC : stk_top;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         stack_err <= 1'b0;
        else if ((push & stk_full) | (pop & stk_empty))     stack_err <= 1'b1;
    end
`else
    logic unused_stack_flags;
    assign unused_stack_flags = &{1'b0, stk_full, stk_empty};
    assign ret_pc    = stk_top;
    assign stack_err = 1'b0;
`endif

    // NOTE: all sequential state uses non-blocking assignment so the chain shifts as true registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            for (int i = 0; i < PIPE_DEPTH; i++) chain[i] <= '0;
            state     <= BOOT;
            flush_cnt <= '0;
            squash    <= 1'b1;
            jmp_rst   <= 1'b0;
            brx_rst   <= 1'b0;
        end else begin
            jmp_rst <= evaluate & jump;
            brx_rst <= evaluate & pc_brx;

            if (advance) begin
                chain[0] <= pc;
                for (int i = 1; i < PIPE_DEPTH; i++) chain[i] <= chain[i-1];
                if (pop)                       pc <= ret_pc;
                else if (evaluate & jump)      pc <= jmp_target;
                else if (evaluate & br_taken)  pc <= cur_pc + sext10(I_field);
                else                           pc <= pc + 16'd1;
            end

            case (state)
                BOOT: begin
                    state  <= RUN;
                    squash <= 1'b0;
                end
                RUN: begin
                    if (redirect) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                        squash    <= 1'b1;
                    end
                end
                FLUSH: begin
                    // one squashed slot per advancing cycle until the wrong-path fetches drain
                    if (advance) begin
                        if (flush_cnt == 3'(PIPE_DEPTH - 1)) begin
                            state  <= RUN;
                            squash <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state  <= BOOT;
                    squash <= 1'b1;
                end
            endcase
        end
    end

endmodule
